// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter: widths,
// requester identifiers and the arbiter state encoding.
package regfile_pkg;

  localparam int REG_AW   = 4;
  localparam int REG_DW   = 8;
  localparam int NUM_REGS = 16;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic {
    ST_RR     = 1'b0,
    ST_LOCK_A = 1'b1
  } state_t;

  // Register 0 is hardwired; writes to it are consumed but never enabled.
  function automatic logic is_writable(input logic [REG_AW-1:0] addr);
    return (addr != {REG_AW{1'b0}});
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter: one-hot grant, ties resolved toward the requester
// named by prio.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] grant
);

  // Grant the lone requester, or the preferred one when both ask.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (prio == REQ_B) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the ALU writeback (A, lockable) and the I/O load path (B)
// onto the single register-file write port; the write itself is registered.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [REG_AW-1:0] a_addr,
  input  logic [REG_DW-1:0] a_data,
  input  logic              a_lock,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [REG_AW-1:0] b_addr,
  input  logic [REG_DW-1:0] b_data,
  output logic              b_ready,
  output logic              we3,
  output logic [REG_AW-1:0] wa3,
  output logic [REG_DW-1:0] wd3,
  output logic              grant_b
);

  state_t            state_r;
  logic              last_b_r;
  logic              we3_r;
  logic [REG_AW-1:0] wa3_r;
  logic [REG_DW-1:0] wd3_r;
  logic              grant_b_r;

  logic              tie_prio_s;
  logic [1:0]        grant_s;
  logic              a_xfer_s;
  logic              b_xfer_s;
  logic [REG_AW-1:0] wr_addr_s;
  logic [REG_DW-1:0] wr_data_s;

  // Tie-break preference: A while locked or in fixed mode, else whoever lost last.
  always_comb begin
    tie_prio_s = REQ_A;
    if (state_r == ST_LOCK_A) begin
      tie_prio_s = REQ_A;
    end else if (PRIO_MODE != 0) begin
      tie_prio_s = REQ_A;
    end else begin
      tie_prio_s = ~last_b_r;
    end
  end

  rr_arb2 u_arb (
    .req   ({b_valid, a_valid}),
    .prio  (tie_prio_s),
    .grant (grant_s)
  );

  assign a_ready   = grant_s[REQ_A] & ~reset;
  assign b_ready   = grant_s[REQ_B] & ~reset;
  assign a_xfer_s  = a_valid & a_ready;
  assign b_xfer_s  = b_valid & b_ready;
  assign wr_addr_s = b_xfer_s ? b_addr : a_addr;
  assign wr_data_s = b_xfer_s ? b_data : a_data;

  // Lock FSM, last-grant pointer and the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_RR;
      last_b_r  <= 1'b1;
      we3_r     <= 1'b0;
      wa3_r     <= {REG_AW{1'b0}};
      wd3_r     <= {REG_DW{1'b0}};
      grant_b_r <= 1'b0;
    end else begin
      we3_r     <= (a_xfer_s | b_xfer_s) & is_writable(wr_addr_s);
      grant_b_r <= b_xfer_s;
      if (a_xfer_s | b_xfer_s) begin
        wa3_r    <= wr_addr_s;
        wd3_r    <= wr_data_s;
        last_b_r <= b_xfer_s;
      end
      case (state_r)
        ST_RR: begin
          if (a_xfer_s & a_lock) begin
            state_r <= ST_LOCK_A;
          end
        end
        ST_LOCK_A: begin
          if (~a_lock & (a_xfer_s | ~a_valid)) begin
            state_r <= ST_RR;
          end
        end
        default: state_r <= ST_RR;
      endcase
    end
  end

  assign we3     = we3_r;
  assign wa3     = wa3_r;
  assign wd3     = wd3_r;
  assign grant_b = grant_b_r;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: round-robin and fixed-priority
// instances share stimulus and are checked against a behavioural model.
module tb_regfile_wr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, a_lock, b_valid;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;

  logic [1:0]      a_rdy, b_rdy, we, gb;
  logic [1:0][3:0] wa;
  logic [1:0][7:0] wd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.PRIO_MODE(0)) u_rr (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_lock(a_lock), .a_ready(a_rdy[0]),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_rdy[0]),
    .we3(we[0]), .wa3(wa[0]), .wd3(wd[0]), .grant_b(gb[0])
  );

  regfile_wr_arbiter #(.PRIO_MODE(1)) u_fp (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_lock(a_lock), .a_ready(a_rdy[1]),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_rdy[1]),
    .we3(we[1]), .wa3(wa[1]), .wd3(wd[1]), .grant_b(gb[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: per instance, whether A holds a lock and whether B won last.
  logic [1:0] m_locked = 2'b00;
  logic [1:0] m_last_b = 2'b11;
  logic [1:0] e_we = 2'b00;
  logic [1:0] e_gb = 2'b00;
  logic [3:0] e_wa [2];
  logic [7:0] e_wd [2];
  logic       m_ea, m_eb;

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d_we3", m), we[m], e_we[m]);
      if (e_we[m]) begin
        chk($sformatf("m%0d_wa3", m), wa[m], e_wa[m]);
        chk($sformatf("m%0d_wd3", m), wd[m], e_wd[m]);
        chk($sformatf("m%0d_grant_b", m), gb[m], e_gb[m]);
      end
      if (reset) begin
        m_ea = 1'b0;
        m_eb = 1'b0;
      end else begin
        if (!a_valid)                       m_eb = b_valid;
        else if (!b_valid)                  m_eb = 1'b0;
        else if (m_locked[m] || m == 1)     m_eb = 1'b0;
        else                                m_eb = !m_last_b[m];
        m_ea = a_valid && !m_eb;
      end
      chk($sformatf("m%0d_a_ready", m), a_rdy[m], m_ea);
      chk($sformatf("m%0d_b_ready", m), b_rdy[m], m_eb);
      if (reset) begin
        m_locked[m] = 1'b0;
        m_last_b[m] = 1'b1;
        e_we[m]     = 1'b0;
      end else begin
        e_we[m] = (m_ea || m_eb) && ((m_eb ? b_addr : a_addr) != 4'd0);
        e_wa[m] = m_eb ? b_addr : a_addr;
        e_wd[m] = m_eb ? b_data : a_data;
        e_gb[m] = m_eb;
        if (m_ea || m_eb) m_last_b[m] = m_eb;
        if (m_ea && a_lock)                                    m_locked[m] = 1'b1;
        else if (!a_lock && ((m_ea && a_valid) || !a_valid))   m_locked[m] = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_lock = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  int acnt;

  initial begin
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_lock = 1'b0;
    a_addr = 4'd0; a_data = 8'h00; b_addr = 4'd0; b_data = 8'h00;
    cyc(); cyc();
    chk("rst_we3", we[0], 1'b0);
    chk("rst_wa3", wa[0], 4'd0);
    chk("rst_wd3", wd[0], 8'h00);
    chk("rst_grant_b", gb[0], 1'b0);
    a_valid = 1'b1; b_valid = 1'b1; #1;
    chk("rst_a_ready", a_rdy[0], 1'b0);
    chk("rst_b_ready", b_rdy[0], 1'b0);

    // A alone, first cycle out of reset
    reset = 1'b0; b_valid = 1'b0; a_addr = 4'd3; a_data = 8'h5A; #1;
    chk("a_only_ready", a_rdy[0], 1'b1);
    cyc();
    a_valid = 1'b0;
    chk("a_only_we3", we[0], 1'b1);
    chk("a_only_wa3", wa[0], 4'd3);
    chk("a_only_wd3", wd[0], 8'h5A);
    chk("a_only_grant_b", gb[0], 1'b0);

    // Round-robin contention
    rst_pulse();
    a_valid = 1'b1; a_addr = 4'd1; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 4'd2; b_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_a_ready", a_rdy[0], (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("rr_b_ready", b_rdy[0], (i % 2 == 1) ? 1'b1 : 1'b0);
      cyc();
      chk("rr_wa3", wa[0], (i % 2 == 1) ? 4'd2 : 4'd1);
      chk("rr_wd3", wd[0], (i % 2 == 1) ? 8'h22 : 8'h11);
    end

    // Lock burst keeps B waiting
    rst_pulse();
    a_valid = 1'b1; b_valid = 1'b1; b_addr = 4'd8; b_data = 8'hB8;
    for (int i = 0; i < 3; i++) begin
      a_lock = (i < 2) ? 1'b1 : 1'b0;
      a_addr = 4'(5 + i);
      a_data = 8'(8'hA1 + i);
      #1;
      chk("lock_b_wait", b_rdy[0], 1'b0);
      cyc();
      chk("lock_wa3", wa[0], 4'(5 + i));
    end
    a_valid = 1'b0; a_lock = 1'b0; #1;
    chk("lock_b_granted", b_rdy[0], 1'b1);
    cyc();
    chk("lock_b_wa3", wa[0], 4'd8);
    chk("lock_b_grant_b", gb[0], 1'b1);
    a_valid = 1'b1; #1;
    chk("unlock_tie_a", a_rdy[0], 1'b1);
    cyc(); #1;
    chk("unlock_tie_b", b_rdy[0], 1'b1);
    cyc();

    // Register 0 write is consumed but not enabled
    a_valid = 1'b0; b_valid = 1'b1; b_addr = 4'd0; b_data = 8'hFF; #1;
    chk("r0_b_ready", b_rdy[0], 1'b1);
    cyc();
    chk("r0_we3", we[0], 1'b0);

    // Reset in the middle of traffic
    b_valid = 1'b0; a_valid = 1'b1; a_addr = 4'd4; a_data = 8'h44;
    cyc();
    a_addr = 4'd9; a_data = 8'h99; b_valid = 1'b1; b_addr = 4'd10; b_data = 8'hAA;
    reset = 1'b1; #1;
    chk("midrst_a_ready", a_rdy[0], 1'b0);
    chk("midrst_b_ready", b_rdy[0], 1'b0);
    cyc();
    chk("midrst_we3", we[0], 1'b0);
    reset = 1'b0; #1;
    chk("midrst_first_a", a_rdy[0], 1'b1);
    cyc();
    chk("midrst_wa3", wa[0], 4'd9);

    // Fixed priority instance always favours A
    rst_pulse();
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 4'd12; b_addr = 4'd13;
    acnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (a_rdy[1] === 1'b1) acnt++;
      chk("fp_b_ready", b_rdy[1], 1'b0);
      cyc();
    end
    chk("fp_a_grants", acnt, 5);

    a_valid = 1'b0; b_valid = 1'b0;
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter PRIO_MODE, default 0; 0 = round-robin between requesters, 1 = fixed priority to requester A.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-005 a_addr  input  4  destination register for requester A.
REQ-006 a_data  input  8  write data for requester A.
REQ-007 a_lock  input  1  requester A asks to keep the port for a burst.
REQ-008 a_ready  output  1  requester A's write is accepted this cycle.
REQ-009 b_valid, b_addr, b_data, b_ready  in/in/in/out  1/4/8/1  same as the A signals, for requester B (I/O load path); B has no lock.
REQ-010 we3  output  1  register-file write enable.
REQ-011 wa3  output  4  register-file write address.
REQ-012 wd3  output  8  register-file write data.
REQ-013 grant_b  output  1  registered; the write on we3/wa3/wd3 came from B.

Function
REQ-014 A transfer SHALL occur when x_valid and x_ready are both 1 on a rising edge; x_ready SHALL be combinational from the valids and the arbiter state, never from the data.
REQ-015 At most one of a_ready/b_ready SHALL be 1 in any cycle; a_ready or b_ready SHALL be 1 whenever at least one valid is 1 (work-conserving).
REQ-016 Write outputs SHALL be registered: an accepted write appears on we3/wa3/wd3 exactly one cycle after acceptance, for exactly one cycle.
REQ-017 An accepted write with address 0 SHALL be consumed (ready=1) but SHALL drive we3=0 in the following cycle; wa3/wd3 are don't-care then.
REQ-018 With no accepted write in the previous cycle, we3 SHALL be 0.
REQ-019 The FSM SHALL have states RR and LOCK_A.
REQ-020 RR with PRIO_MODE=0: when both valids are 1, grant the requester that was not granted most recently; the last-grant pointer updates only on a transfer.
REQ-021 RR with PRIO_MODE=1: when both valids are 1, grant A.
REQ-022 RR to LOCK_A SHALL occur on an A transfer with a_lock=1.
REQ-023 In LOCK_A, A SHALL have absolute priority; B is granted only when a_valid=0.
REQ-024 LOCK_A to RR SHALL occur on the first A transfer with a_lock=0, or in any cycle with a_lock=0 and a_valid=0.
REQ-025 Same-address simultaneous requests SHALL NOT be merged; the loser stays pending and is written in a later cycle, so the last write wins in grant order.
REQ-026 Requester inputs SHALL be held stable while valid=1 and ready=0; the arbiter does not buffer ungranted requests.

Reset
REQ-027 While reset=1: we3=0, wa3=0, wd3=0, grant_b=0, a_ready=0, b_ready=0, FSM=RR, last-grant pointer=B (A wins the first tie).
REQ-028 A write accepted in the cycle reset rises SHALL be discarded; we3 stays 0 in the following cycle.
REQ-029 The first transfer SHALL be possible in the first cycle after reset deasserts.

Structure
REQ-030 Shared package regfile_pkg SHALL hold REG_AW=4, REG_DW=8, NUM_REGS=16, requester IDs REQ_A=0/REQ_B=1, and the FSM state encoding.
REQ-031 The grant logic SHALL be a sub-module rr_arb2 (2 requests, priority input, one-hot grant); the FSM, lock handling and output register stay in the top module.

Verification
REQ-032 A only: a_valid=1, a_addr=3, a_data=8'h5A -> a_ready=1 the same cycle; next cycle we3=1, wa3=3, wd3=8'h5A, grant_b=0.
REQ-033 Contention, PRIO_MODE=0: both valid for 4 cycles (A: r1/11, B: r2/22) -> grants A,B,A,B; we3 written r1,r2,r1,r2 one cycle later.
REQ-034 Lock: A sends 3 writes with a_lock=1,1,0 while b_valid=1 -> B waits 3 cycles and is granted in cycle 4; FSM returns to RR.
REQ-035 Register 0: B writes addr 0, data FF -> b_ready=1; next cycle we3=0.
REQ-036 Reset mid-operation: both valid and reset asserted for 1 cycle -> next cycle we3=0; after release A is granted first.
REQ-037 PRIO_MODE=1: both valid continuously for 5 cycles -> 5 A grants, b_ready=0 throughout.
